ysyx_mem_arbiter: RTL and testbench

// Shares one AXI4 master port (64-bit data, single-beat) between the IFU fetch port and the LSU load/store ports.

---
 rtl/ysyx_mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_ysyx_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_mem_arbiter.sv
// rtl/ysyx_mem_arbiter.sv - IFU/LSU arbiter onto one single-beat 64-bit AXI4 master
// Registered grant, one transaction in flight, starvation guard for fetch, 32/64 lane steering.
module ysyx_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_rsize,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_rvalid_o,
  input  logic              lsu_awvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wstrb,
  output logic              lsu_bvalid_o,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arsize,
  output logic [7:0]        m_arlen,
  output logic [1:0]        m_arburst,
  output logic [3:0]        m_arid,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [63:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              m_rready,
  output logic              m_awvalid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awsize,
  output logic [7:0]        m_awlen,
  output logic [1:0]        m_awburst,
  output logic [3:0]        m_awid,
  input  logic              m_awready,
  output logic              m_wvalid,
  output logic [63:0]       m_wdata,
  output logic [7:0]        m_wstrb,
  output logic              m_wlast,
  input  logic              m_wready,
  input  logic              m_bvalid,
  input  logic [1:0]        m_bresp,
  output logic              m_bready,
  output logic              err_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_D = 3'd2;
  localparam logic [2:0] S_WR_A = 3'd3;
  localparam logic [2:0] S_WR_B = 3'd4;

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  logic [2:0]        r_state;
  logic              r_owner_ifu;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic [63:0]       r_wdata;
  logic [7:0]        r_wstrb;
  logic              r_aw_done;
  logic              r_w_done;
  logic [SW-1:0]     r_starve;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ifu_rvalid;
  logic              r_lsu_rvalid;
  logic              r_lsu_bvalid;
  logic              r_err;

  logic              w_idle;
  logic              w_ifu_force;
  logic              w_grant_wr;
  logic              w_grant_ld;
  logic              w_grant_ifu;
  logic              w_aw_fin;
  logic              w_w_fin;
  logic [DATA_W-1:0] w_wdata_sh;
  logic [3:0]        w_wstrb_sh;
  logic [2:0]        w_awsize;
  logic [DATA_W-1:0] w_rdata_lane;
  logic              w_unused;

  assign w_idle      = (r_state == S_IDLE);
  // Once fetch has been passed over STARVE_MAX times it beats any LSU request.
  assign w_ifu_force = ifu_arvalid && (r_starve == STARVE_LIM);
  assign w_grant_wr  = w_idle && !w_ifu_force && lsu_awvalid;
  assign w_grant_ld  = w_idle && !w_ifu_force && !lsu_awvalid && lsu_arvalid;
  assign w_grant_ifu = w_idle && ifu_arvalid && (w_ifu_force || (!lsu_awvalid && !lsu_arvalid));

  assign w_aw_fin = r_aw_done || (m_awvalid && m_awready);
  assign w_w_fin  = r_w_done  || (m_wvalid  && m_wready);

  assign w_wdata_sh   = lsu_wdata << {lsu_awaddr[1:0], 3'b000};
  assign w_wstrb_sh   = lsu_wstrb << lsu_awaddr[1:0];
  assign w_rdata_lane = r_addr[2] ? m_rdata[63:32] : m_rdata[31:0];

  always_comb begin
    w_awsize = 3'd2;
    case ($countones(lsu_wstrb))
      1:       w_awsize = 3'd0;
      2:       w_awsize = 3'd1;
      default: w_awsize = 3'd2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner_ifu  <= 1'b0;
      r_addr       <= '0;
      r_size       <= 3'd0;
      r_wdata      <= 64'd0;
      r_wstrb      <= 8'd0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_starve     <= '0;
      r_rdata      <= '0;
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_bvalid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_bvalid <= 1'b0;
      r_err        <= 1'b0;

      if (!ifu_arvalid || w_grant_ifu) begin
        r_starve <= '0;
      end else if ((w_grant_wr || w_grant_ld) && (r_starve != STARVE_LIM)) begin
        r_starve <= r_starve + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_wr) begin
            r_addr    <= lsu_awaddr;
            r_size    <= w_awsize;
            r_wdata   <= {w_wdata_sh, w_wdata_sh};
            r_wstrb   <= lsu_awaddr[2] ? {w_wstrb_sh, 4'b0000} : {4'b0000, w_wstrb_sh};
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= S_WR_A;
          end else if (w_grant_ld) begin
            r_owner_ifu <= 1'b0;
            r_addr      <= lsu_araddr;
            r_size      <= lsu_rsize;
            r_state     <= S_RD_A;
          end else if (w_grant_ifu) begin
            r_owner_ifu <= 1'b1;
            r_addr      <= ifu_araddr;
            r_size      <= 3'b010;
            r_state     <= S_RD_A;
          end
        end
        S_RD_A: if (m_arready) r_state <= S_RD_D;
        S_RD_D: begin
          if (m_rvalid) begin
            r_rdata      <= w_rdata_lane;
            r_ifu_rvalid <= r_owner_ifu;
            r_lsu_rvalid <= !r_owner_ifu;
            r_err        <= |m_rresp;
            r_state      <= S_IDLE;
          end
        end
        S_WR_A: begin
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= S_WR_B;
          end else begin
            r_aw_done <= w_aw_fin;
            r_w_done  <= w_w_fin;
          end
        end
        S_WR_B: begin
          if (m_bvalid) begin
            r_lsu_bvalid <= 1'b1;
            r_err        <= |m_bresp;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_arvalid = (r_state == S_RD_A);
  assign m_araddr  = r_addr;
  assign m_arsize  = r_size;
  assign m_arlen   = 8'd0;
  assign m_arburst = 2'b01;
  assign m_arid    = 4'd0;
  assign m_rready  = (r_state == S_RD_D);

  assign m_awvalid = (r_state == S_WR_A) && !r_aw_done;
  assign m_awaddr  = r_addr;
  assign m_awsize  = r_size;
  assign m_awlen   = 8'd0;
  assign m_awburst = 2'b01;
  assign m_awid    = 4'd0;
  assign m_wvalid  = (r_state == S_WR_A) && !r_w_done;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_wlast   = 1'b1;
  assign m_bready  = (r_state == S_WR_B);

  assign ifu_rdata_o  = r_rdata;
  assign ifu_rvalid_o = r_ifu_rvalid;
  assign lsu_rdata_o  = r_rdata;
  assign lsu_rvalid_o = r_lsu_rvalid;
  assign lsu_bvalid_o = r_lsu_bvalid;
  assign err_o        = r_err;

  assign w_unused = &{1'b0, m_rlast};

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb/tb_ysyx_mem_arbiter.sv - directed vector bench for ysyx_mem_arbiter
// Vector table for single transactions, hand sequences for arbitration and reset corners.
module tb_ysyx_mem_arbiter;

  localparam logic [31:0] IFU_A = 32'h8000_0000;
  localparam logic [31:0] LSU_A = 32'h8000_0100;

  logic        clk;
  logic        rst;
  logic        ifu_arvalid;
  logic [31:0] ifu_araddr;
  logic [31:0] ifu_rdata_o;
  logic        ifu_rvalid_o;
  logic        lsu_arvalid;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_rsize;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rvalid_o;
  logic        lsu_awvalid;
  logic [31:0] lsu_awaddr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_bvalid_o;
  logic        m_arvalid;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  logic [7:0]  m_arlen;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arid;
  logic        m_arready;
  logic        m_rvalid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rready;
  logic        m_awvalid;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awsize;
  logic [7:0]  m_awlen;
  logic [1:0]  m_awburst;
  logic [3:0]  m_awid;
  logic        m_awready;
  logic        m_wvalid;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wready;
  logic        m_bvalid;
  logic [1:0]  m_bresp;
  logic        m_bready;
  logic        err_o;

  int n_vec = 0;
  int n_err = 0;

  ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_rsize(lsu_rsize),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_bvalid_o(lsu_bvalid_o),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arlen(m_arlen),
    .m_arburst(m_arburst), .m_arid(m_arid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awlen(m_awlen),
    .m_awburst(m_awburst), .m_awid(m_awid), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded, required finish earlier", $time);
    $fatal(1);
  end

  typedef struct {
    bit          is_wr;
    bit          is_ifu;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  rsize;
    logic [63:0] rd64;
    logic [1:0]  resp;
    int          d_a;
    int          d_w;
    logic [63:0] exp_data;
    logic [7:0]  exp_strb;
    logic [2:0]  exp_size;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] idle_outs();
    return {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
            ifu_rvalid_o, lsu_rvalid_o, lsu_bvalid_o, err_o};
  endfunction

  task automatic do_read(input vec_t v);
    if (v.is_ifu) begin
      ifu_arvalid = 1'b1;
      ifu_araddr  = v.addr;
    end else begin
      lsu_arvalid = 1'b1;
      lsu_araddr  = v.addr;
      lsu_rsize   = v.rsize;
    end
    @(negedge clk);
    for (int c = 0; c <= v.d_a; c++) begin
      chk("rd_arvalid", m_arvalid, 1);
      chk("rd_araddr", m_araddr, v.addr);
      chk("rd_arsize", m_arsize, v.exp_size);
      m_arready = (c == v.d_a);
      @(negedge clk);
    end
    m_arready = 1'b0;
    chk("rd_rready", m_rready, 1);
    chk("rd_arvalid_drop", m_arvalid, 0);
    m_rvalid = 1'b1;
    m_rdata  = v.rd64;
    m_rresp  = v.resp;
    @(negedge clk);
    m_rvalid = 1'b0;
    m_rresp  = 2'b00;
    chk("rd_pulse_owner", {ifu_rvalid_o, lsu_rvalid_o}, v.is_ifu ? 2'b10 : 2'b01);
    chk("rd_data", v.is_ifu ? ifu_rdata_o : lsu_rdata_o, v.exp_data);
    chk("rd_err", err_o, v.exp_err);
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b0;
    @(negedge clk);
    chk("rd_after", idle_outs(), 0);
  endtask

  task automatic do_write(input vec_t v);
    int mx;
    mx = (v.d_a > v.d_w) ? v.d_a : v.d_w;
    lsu_awvalid = 1'b1;
    lsu_awaddr  = v.addr;
    lsu_wdata   = v.wdata;
    lsu_wstrb   = v.wstrb;
    @(negedge clk);
    chk("wr_awaddr", m_awaddr, v.addr);
    chk("wr_wdata", m_wdata, v.exp_data);
    chk("wr_wstrb", m_wstrb, v.exp_strb);
    chk("wr_awsize", m_awsize, v.exp_size);
    chk("wr_wlast", m_wlast, 1);
    for (int c = 0; c <= mx; c++) begin
      chk("wr_awvalid", m_awvalid, c <= v.d_a);
      chk("wr_wvalid", m_wvalid, c <= v.d_w);
      chk("wr_bvalid_early", lsu_bvalid_o, 0);
      m_awready = (c == v.d_a);
      m_wready  = (c == v.d_w);
      @(negedge clk);
    end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    chk("wr_valids_drop", {m_awvalid, m_wvalid}, 0);
    chk("wr_bready", m_bready, 1);
    m_bvalid = 1'b1;
    m_bresp  = v.resp;
    @(negedge clk);
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    chk("wr_bvalid_o", lsu_bvalid_o, 1);
    chk("wr_err", err_o, v.exp_err);
    lsu_awvalid = 1'b0;
    @(negedge clk);
    chk("wr_after", idle_outs(), 0);
  endtask

  // Completes one read that the arbiter has already granted; owner is told apart by address.
  task automatic serve_one(input bit exp_ifu, input bit drop_ifu, input bit drop_lsu);
    chk("arb_arvalid", m_arvalid, 1);
    chk("arb_owner", m_araddr, exp_ifu ? IFU_A : LSU_A);
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    m_rvalid = 1'b0;
    chk("arb_pulse", {ifu_rvalid_o, lsu_rvalid_o}, exp_ifu ? 2'b10 : 2'b01);
    if (drop_ifu) ifu_arvalid = 1'b0;
    if (drop_lsu) lsu_arvalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    //        wr ifu addr          wdata          strb rsz rd64                   resp da dw exp_data               strb   sz  err
    vecs[0] = '{0, 1, 32'h8000_0004, 32'h0,         4'h0, 3'd0, 64'h1111_2222_3333_4444, 2'b00, 2, 0, 64'h1111_2222,        8'h00, 3'd2, 0};
    vecs[1] = '{0, 0, 32'h8000_0010, 32'h0,         4'h0, 3'd2, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0, 0, 64'hCCCC_DDDD,        8'h00, 3'd2, 0};
    vecs[2] = '{0, 0, 32'h8000_0007, 32'h0,         4'h0, 3'd0, 64'h0102_0304_0506_0708, 2'b00, 1, 0, 64'h0102_0304,        8'h00, 3'd0, 0};
    vecs[3] = '{0, 0, 32'h8000_0002, 32'h0,         4'h0, 3'd1, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 0, 0, 64'hCAFE_F00D,        8'h00, 3'd1, 1};
    vecs[4] = '{1, 0, 32'h8000_0007, 32'h0000_00AB, 4'h1, 3'd0, 64'h0, 2'b00, 0, 0, 64'hAB00_0000_AB00_0000, 8'h80, 3'd0, 0};
    vecs[5] = '{1, 0, 32'h8000_0000, 32'h1234_5678, 4'hF, 3'd0, 64'h0, 2'b00, 0, 3, 64'h1234_5678_1234_5678, 8'h0F, 3'd2, 0};
    vecs[6] = '{1, 0, 32'h8000_0006, 32'h0000_BEEF, 4'h3, 3'd0, 64'h0, 2'b11, 3, 0, 64'hBEEF_0000_BEEF_0000, 8'hC0, 3'd1, 1};
    vecs[7] = '{1, 0, 32'h8000_0001, 32'h0000_005A, 4'h1, 3'd0, 64'h0, 2'b00, 1, 1, 64'h0000_5A00_0000_5A00, 8'h02, 3'd0, 0};

    rst = 1'b1;
    ifu_arvalid = 1'b0; ifu_araddr = 32'h0;
    lsu_arvalid = 1'b0; lsu_araddr = 32'h0; lsu_rsize = 3'd0;
    lsu_awvalid = 1'b0; lsu_awaddr = 32'h0; lsu_wdata = 32'h0; lsu_wstrb = 4'h0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 64'h0; m_rresp = 2'b00; m_rlast = 1'b1;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;

    repeat (2) @(negedge clk);
    chk("reset_outs", idle_outs(), 0);
    chk("tied_ar", {m_arlen, m_arburst, m_arid}, {8'd0, 2'b01, 4'd0});
    chk("tied_aw", {m_awlen, m_awburst, m_awid, m_wlast}, {8'd0, 2'b01, 4'd0, 1'b1});
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", idle_outs(), 0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i]);
      else               do_read(vecs[i]);
    end

    // Contention: both raised together, LSU first then IFU, nothing afterwards.
    ifu_arvalid = 1'b1; ifu_araddr = IFU_A;
    lsu_arvalid = 1'b1; lsu_araddr = LSU_A; lsu_rsize = 3'd2;
    @(negedge clk);
    serve_one(1'b0, 1'b0, 1'b1);
    serve_one(1'b1, 1'b1, 1'b0);
    repeat (2) begin
      chk("cont_quiet", idle_outs(), 0);
      @(negedge clk);
    end

    // Starvation: LSU holds valid continuously; IFU must win every fifth grant.
    ifu_arvalid = 1'b1;
    lsu_arvalid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      serve_one(i == 4 || i == 9, i == 9, i == 9);
    end
    chk("starve_quiet", idle_outs(), 0);

    // Asynchronous reset while waiting for read data; stray rvalid in IDLE is ignored.
    lsu_arvalid = 1'b1; lsu_araddr = LSU_A;
    @(negedge clk);
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    chk("rst_pre_rready", m_rready, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", idle_outs(), 0);
    lsu_arvalid = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    m_rresp  = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stray_rvalid", idle_outs(), 0);
    m_rvalid = 1'b0;
    m_rresp  = 2'b00;
    @(negedge clk);
    chk("rst_post_outs", idle_outs(), 0);

    do_read(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
